up_counter_sync_reset: RTL and testbench

//   Free-running binary up-counter with synchronous, active-low reset.

---
 rtl/up_counter_sync_reset.sv | 50 +++++
 tb/tb_up_counter_sync_reset.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/up_counter_sync_reset.sv
// Free-running binary up-counter with synchronous active-low reset; wraps to 0 after MAX_VALUE.
// Latency: Q updates on each rising clk edge; the first increment shows one edge after rst is seen high.
// Backpressure: none; counts every cycle while rst is high.
//
// Ports:
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous reset, active low (0 = load RESET_VALUE, 1 = count)
//   Q   : current count, driven straight from the state register
module up_counter_sync_reset #(
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned MAX_VALUE   = (2 ** WIDTH) - 1,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] Q
);

    // Parameters are held as 32-bit integers so the defaults can be computed
    // from WIDTH; narrow them once here so all comparisons are WIDTH wide.
    localparam logic [31:0]      MAX_WIDE = MAX_VALUE;
    localparam logic [31:0]      RST_WIDE = RESET_VALUE;
    localparam logic [WIDTH-1:0] MAX_Q    = MAX_WIDE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_Q    = RST_WIDE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_Q    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Explicit wrap at MAX_Q so a terminal count below 2**WIDTH-1 works;
    // when MAX_Q is all ones the increment would wrap naturally anyway.
    always_comb begin
        q_d = q_q + ONE_Q;
        if (q_q == MAX_Q) begin
            q_d = '0;
        end
    end

    // Reset is only looked at on the clock edge and overrides counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= RST_Q;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_up_counter_sync_reset.sv
// Bench for up_counter_sync_reset: three parameterisations share clk/rst.
// Checks directed timeline scenarios and randomized reset activity against a modular-arithmetic model.
// Outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_up_counter_sync_reset;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] q_a;
    logic [2:0] q_b;
    logic [2:0] q_c;

    always #50 clk = ~clk;

    // Default parameters
    up_counter_sync_reset dut_a (
        .clk (clk),
        .rst (rst),
        .Q   (q_a)
    );

    // Short terminal count
    up_counter_sync_reset #(.WIDTH(3), .MAX_VALUE(5)) dut_b (
        .clk (clk),
        .rst (rst),
        .Q   (q_b)
    );

    // Non-zero reset value
    up_counter_sync_reset #(.WIDTH(3), .MAX_VALUE(6), .RESET_VALUE(2)) dut_c (
        .clk (clk),
        .rst (rst),
        .Q   (q_c)
    );

    int checks   = 0;
    int failures = 0;

    int mdl_a = 0;
    int mdl_b = 0;
    int mdl_c = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Counter behaviour: count modulo (max+1) when running, load reset value otherwise.
    function automatic int next_cnt(input int cur, input bit run, input int maxv, input int rstv);
        return run ? (cur + 1) % (maxv + 1) : rstv;
    endfunction

    // Advance one rising edge, update the model with rst as seen at the edge,
    // then compare all three counters.
    task automatic tick(input string tag);
        bit run;
        @(posedge clk);
        run   = rst;
        mdl_a = next_cnt(mdl_a, run, 3, 0);
        mdl_b = next_cnt(mdl_b, run, 5, 0);
        mdl_c = next_cnt(mdl_c, run, 6, 2);
        #1;
        check({tag, "_a"}, int'(q_a), mdl_a);
        check({tag, "_b"}, int'(q_b), mdl_b);
        check({tag, "_c"}, int'(q_c), mdl_c);
    endtask

    initial begin
        int exp_a [5];
        int exp_b [7];
        int prev;

        // Scenario 1: reset at the 50 ns edge
        tick("reset");
        check("reset_val_a", int'(q_a), 0);
        check("reset_val_c", int'(q_c), 2);

        // Scenarios 2 and 3: count 1,2,3 then wrap 0,1 at 150..550 ns
        @(negedge clk);
        rst = 1'b1;
        exp_a = '{1, 2, 3, 0, 1};
        for (int i = 0; i < 5; i++) begin
            tick("count");
            check("count_seq_a", int'(q_a), exp_a[i]);
        end

        // Scenario 4: reset while Q == 2, then hold at 0
        for (int i = 0; i < 8 && mdl_a != 2; i++) tick("to_two");
        check("at_two_a", int'(q_a), 2);
        @(negedge clk);
        rst = 1'b0;
        tick("midrst");
        check("midrst_a", int'(q_a), 0);
        tick("midrst_hold");
        tick("midrst_hold");
        check("midrst_hold_a", int'(q_a), 0);

        // Reset while sitting at terminal count
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8 && mdl_a != 3; i++) tick("to_max");
        @(negedge clk);
        rst = 1'b0;
        tick("maxrst");
        check("maxrst_a", int'(q_a), 0);

        // Scenario 5: a low pulse that never spans an edge is ignored
        @(negedge clk);
        rst = 1'b1;
        tick("pre_glitch");
        prev = int'(q_a);
        #20 rst = 1'b0;
        #20 rst = 1'b1;
        tick("glitch");
        check("glitch_a", int'(q_a), (prev + 1) % 4);

        // Scenario 6: WIDTH=3, MAX_VALUE=5 sequence after reset
        @(negedge clk);
        rst = 1'b0;
        tick("sweep_rst");
        @(negedge clk);
        rst = 1'b1;
        exp_b = '{1, 2, 3, 4, 5, 0, 1};
        for (int i = 0; i < 7; i++) begin
            tick("sweep");
            check("sweep_seq_b", int'(q_b), exp_b[i]);
        end

        // Randomized reset activity, roughly one cycle in eight held in reset
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 7) != 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
